// File: rtl/stim_pattern_gen.sv
// rtl/stim_pattern_gen.sv - stimulus sweep generator (binary up/down, Gray, walking-one)
module stim_pattern_gen #(
    parameter int WIDTH = 5,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             ready,
    output logic [WIDTH-1:0] vec,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_GAP     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0]   MODE_UP   = 2'b00;
    localparam logic [1:0]   MODE_GRAY = 2'b01;
    localparam logic [1:0]   MODE_WALK = 2'b10;
    localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] N_POW   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] N_WALK  = (WIDTH + 1)'(WIDTH);
    localparam bit             HAS_GAP = (GAP > 0);
    localparam int             GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [7:0]     GAP_LAST_V = GAP_LAST[7:0];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [WIDTH:0]   r_idx;
    logic [WIDTH:0]   r_count;
    logic [WIDTH-1:0] r_vec;
    logic [7:0]       r_gap_cnt;

    logic             w_xfer;
    logic [WIDTH:0]   w_count_inc;
    logic [WIDTH:0]   w_idx_inc;
    logic [WIDTH:0]   w_n;
    logic             w_final;
    logic             w_gap_end;

    // Down mode uses ~i, which equals N-1-i because N is 2^WIDTH there.
    function automatic logic [WIDTH-1:0] f_pattern(input logic [1:0] m,
                                                   input logic [WIDTH-1:0] i);
        logic [WIDTH-1:0] v;
        case (m)
            MODE_UP:   v = i;
            MODE_GRAY: v = i ^ (i >> 1);
            MODE_WALK: v = {{(WIDTH-1){1'b0}}, 1'b1} << i;
            default:   v = ~i;
        endcase
        return v;
    endfunction

    assign w_xfer      = (r_state == S_PRESENT) && ready;
    assign w_count_inc = r_count + ONE;
    assign w_idx_inc   = r_idx + ONE;
    assign w_n         = (r_mode == MODE_WALK) ? N_WALK : N_POW;
    assign w_final     = (w_count_inc == w_n);
    assign w_gap_end   = (r_gap_cnt == GAP_LAST_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_xfer) begin
                    if (w_final) begin
                        w_state_nxt = S_DONE;
                    end else if (HAS_GAP) begin
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_gap_end) begin
                    w_state_nxt = S_PRESENT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        valid = (r_state == S_PRESENT);
        busy  = (r_state == S_PRESENT) || (r_state == S_GAP);
        done  = (r_state == S_DONE);
        vec   = r_vec;
        count = r_count;
    end

    // A transfer that coincides with abort has completed, so it is still counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= MODE_UP;
            r_idx     <= '0;
            r_count   <= '0;
            r_vec     <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode    <= mode;
                        r_idx     <= '0;
                        r_count   <= '0;
                        r_gap_cnt <= '0;
                        r_vec     <= f_pattern(mode, '0);
                    end
                end
                S_PRESENT: begin
                    if (w_xfer) begin
                        r_count <= w_count_inc;
                        if (!abort && !w_final) begin
                            r_idx     <= w_idx_inc;
                            r_gap_cnt <= '0;
                            if (!HAS_GAP) begin
                                r_vec <= f_pattern(r_mode, w_idx_inc[WIDTH-1:0]);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (!abort) begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                        if (w_gap_end) begin
                            r_vec <= f_pattern(r_mode, r_idx[WIDTH-1:0]);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// tb/tb_stim_pattern_gen.sv - scoreboard bench for stim_pattern_gen
module tb_stim_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_start, a_abort, a_ready;
    logic [1:0] a_mode;
    logic [2:0] a_vec;
    logic       a_valid, a_busy, a_done;
    logic [3:0] a_count;

    logic       b_start, b_abort, b_ready;
    logic [1:0] b_mode;
    logic [4:0] b_vec;
    logic       b_valid, b_busy, b_done;
    logic [5:0] b_count;

    stim_pattern_gen #(.WIDTH(3), .GAP(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .mode(a_mode),
        .ready(a_ready), .vec(a_vec), .valid(a_valid), .busy(a_busy),
        .done(a_done), .count(a_count)
    );

    stim_pattern_gen #(.WIDTH(5), .GAP(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .mode(b_mode),
        .ready(b_ready), .vec(b_vec), .valid(b_valid), .busy(b_busy),
        .done(b_done), .count(b_count)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    bit          gray_chk = 1'b0;
    int          a_done_cnt = 0;
    bit          a_have_prev = 1'b0;
    logic [2:0]  a_prev;
    bit          a_hold = 1'b0;
    logic [2:0]  a_held_vec;
    bit          b_after = 1'b0;
    int          b_gap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int c0, output int cyc);
        cyc = c0;
        while (!a_done && cyc < 400) begin
            step();
            cyc++;
        end
        if (!a_done) chk("a_done_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            a_hold      = 1'b0;
            a_have_prev = 1'b0;
        end else begin
            if (a_hold) begin
                chk("a_valid_held", a_valid, 1);
                chk("a_vec_stable", a_vec, a_held_vec);
            end
            if (a_valid && a_ready) begin
                if (q_a.size() == 0) begin
                    chk("a_extra_xfer", a_vec, 32'hFFFF);
                end else begin
                    chk("a_vec", a_vec, q_a.pop_front());
                    if (gray_chk && a_have_prev)
                        chk("a_gray_1bit", $countones(a_vec ^ a_prev), 1);
                    a_prev      = a_vec;
                    a_have_prev = 1'b1;
                end
            end
            a_hold     = a_valid && !a_ready && !a_abort;
            a_held_vec = a_vec;
            if (!a_busy) a_have_prev = 1'b0;
            if (a_done) a_done_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_after = 1'b0;
        end else begin
            if (b_valid && b_after) begin
                chk("b_gap_len", b_gap, 2);
                b_after = 1'b0;
            end
            if (b_valid && b_ready) begin
                if (q_b.size() == 0) chk("b_extra_xfer", b_vec, 32'hFFFF);
                else chk("b_vec", b_vec, q_b.pop_front());
                b_after = 1'b1;
                b_gap   = 0;
            end else if (b_busy && !b_valid) begin
                b_gap++;
            end
            if (!b_busy) b_after = 1'b0;
        end
    end

    initial begin
        automatic logic [2:0] gray_tbl[8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        automatic logic [4:0] walk_tbl[5] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
        int cyc;
        int dc;
        rst = 1'b1;
        a_start = 0; a_abort = 0; a_ready = 1; a_mode = 2'b00;
        b_start = 0; b_abort = 0; b_ready = 1; b_mode = 2'b00;
        repeat (3) step();
        chk("rst_a_vec", a_vec, 0);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_count", b_count, 0);

        // Binary up, start on first cycle out of reset
        rst = 1'b0;
        for (int i = 0; i < 8; i++) q_a.push_back(i);
        a_mode = 2'b00; a_start = 1;
        dc = a_done_cnt;
        step();
        a_start = 0;
        chk("up_first_valid", a_valid, 1);
        chk("up_first_busy", a_busy, 1);
        chk("up_first_vec", a_vec, 0);
        wait_done_a(1, cyc);
        chk("up_latency", cyc, 9);
        chk("up_done_valid", a_valid, 0);
        chk("up_done_busy", a_busy, 0);
        chk("up_count", a_count, 8);
        step();
        chk("up_done_pulse_len", a_done, 0);
        chk("up_idle_vec_hold", a_vec, 7);
        chk("up_idle_count_hold", a_count, 8);
        chk("up_done_pulses", a_done_cnt - dc, 1);
        chk("up_queue_empty", q_a.size(), 0);

        // Walking-one with GAP=2 on the wide instance
        for (int i = 0; i < 5; i++) q_b.push_back(walk_tbl[i]);
        b_mode = 2'b10; b_start = 1;
        step();
        b_start = 0;
        cyc = 1;
        while (!b_done && cyc < 400) begin
            step();
            cyc++;
        end
        chk("walk_done_seen", b_done, 1);
        chk("walk_latency", cyc, 14);
        chk("walk_count", b_count, 5);
        chk("walk_queue_empty", q_b.size(), 0);
        step();
        chk("walk_done_len", b_done, 0);

        // Gray
        gray_chk = 1'b1;
        for (int i = 0; i < 8; i++) q_a.push_back(gray_tbl[i]);
        a_mode = 2'b01; a_start = 1;
        step();
        a_start = 0;
        wait_done_a(1, cyc);
        chk("gray_latency", cyc, 9);
        chk("gray_count", a_count, 8);
        step();
        gray_chk = 1'b0;
        chk("gray_queue_empty", q_a.size(), 0);

        // Binary down with random backpressure; mode changes after start are ignored
        for (int i = 7; i >= 0; i--) q_a.push_back(i);
        a_mode = 2'b11; a_start = 1;
        step();
        a_start = 0;
        a_mode = 2'b10;
        cyc = 0;
        while (!a_done && cyc < 400) begin
            a_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        a_ready = 1;
        chk("down_done_seen", a_done, 1);
        chk("down_count", a_count, 8);
        step();
        chk("down_queue_empty", q_a.size(), 0);

        // Abort after the 3rd transfer while stalled
        for (int i = 0; i < 3; i++) q_a.push_back(i);
        a_mode = 2'b00; a_start = 1;
        dc = a_done_cnt;
        step();
        a_start = 0;
        repeat (3) step();
        a_ready = 0; a_abort = 1;
        step();
        a_abort = 0;
        chk("abort_valid", a_valid, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_count", a_count, 3);
        chk("abort_done", a_done, 0);
        a_ready = 1;
        step();
        chk("abort_no_done", a_done_cnt - dc, 0);
        chk("abort_queue_empty", q_a.size(), 0);

        // Restart from index 0; abort coincident with the 3rd transfer
        for (int i = 0; i < 3; i++) q_a.push_back(i);
        a_start = 1;
        step();
        a_start = 0;
        chk("restart_vec0", a_vec, 0);
        step();
        step();
        a_abort = 1;
        step();
        a_abort = 0;
        chk("abort_xfer_busy", a_busy, 0);
        chk("abort_xfer_count", a_count, 3);
        step();
        chk("abort_xfer_queue", q_a.size(), 0);

        // start+abort in IDLE is a start; start mid-sweep and in DONE are ignored
        for (int i = 0; i < 8; i++) q_a.push_back(i);
        a_start = 1; a_abort = 1;
        step();
        a_start = 0; a_abort = 0;
        chk("start_abort_busy", a_busy, 1);
        step();
        a_start = 1;
        step();
        a_start = 0;
        wait_done_a(3, cyc);
        chk("midstart_latency", cyc, 9);
        chk("midstart_count", a_count, 8);
        a_start = 1;
        step();
        a_start = 0;
        step();
        chk("done_start_busy", a_busy, 0);
        chk("done_start_valid", a_valid, 0);
        chk("done_start_count", a_count, 8);

        // Reset mid-sweep, then first start straight out of reset
        for (int i = 0; i < 8; i++) q_a.push_back(i);
        a_start = 1;
        step();
        a_start = 0;
        step();
        step();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_vec", a_vec, 0);
        chk("mid_rst_valid", a_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_count", a_count, 0);
        q_a.delete();
        dc = a_done_cnt;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_no_done", a_done_cnt - dc, 0);
        chk("post_rst_busy", a_busy, 0);
        for (int i = 0; i < 8; i++) q_a.push_back(i);
        a_start = 1;
        step();
        a_start = 0;
        chk("post_rst_start_valid", a_valid, 1);
        wait_done_a(1, cyc);
        chk("post_rst_latency", cyc, 9);
        chk("post_rst_count", a_count, 8);
        step();
        chk("post_rst_done_pulses", a_done_cnt - dc, 1);
        chk("post_rst_queue_empty", q_a.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stim_pattern_gen.md
STIM_PATTERN_GEN -- requirements
Module: stim_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 5: width of the generated vector, legal range 2..16.
REQ-002 Parameter GAP, default 0: idle cycles inserted after each accepted vector, legal range 0..255.
REQ-003 Port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: begin a sweep; sampled only in IDLE.
REQ-006 Port abort, input, 1: terminate the sweep in progress.
REQ-007 Port mode, input, 2: sweep mode, where 00 = binary up, 01 = Gray, 10 = walking-one, 11 = binary down; latched on an accepted start.
REQ-008 Port ready, input, 1: downstream accept.
REQ-009 Port vec, output, WIDTH: current stimulus vector.
REQ-010 Port valid, output, 1: vec is presented for transfer.
REQ-011 Port busy, output, 1: a sweep is in progress.
REQ-012 Port done, output, 1: one-cycle pulse when a sweep completes normally.
REQ-013 Port count, output, WIDTH+1: number of vectors transferred in the current or most recent sweep.

Function
REQ-014 The FSM SHALL have the states IDLE, PRESENT, GAP and DONE.
REQ-015 A transfer SHALL occur in any cycle where valid and ready are both high.
REQ-016 IDLE, start=1: latch mode, clear the index and count, drive the first vector, set valid and busy on the next cycle, and enter PRESENT.
REQ-017 In PRESENT, vec and valid SHALL hold stable until a transfer occurs.
REQ-018 On a transfer, count SHALL increment by 1.
REQ-019 On a non-final transfer, the block SHALL enter GAP if GAP>0, otherwise present the next vector on the next cycle.
REQ-020 In GAP, valid SHALL be low for exactly GAP cycles, then the next vector SHALL be presented and the FSM SHALL return to PRESENT.
REQ-021 Vector sequence, index i = 0..N-1: binary up vec=i; Gray vec=i^(i>>1); walking-one vec=1<<i; binary down vec=N-1-i.
REQ-022 N SHALL be 2^WIDTH for the binary and Gray modes, and WIDTH for walking-one.
REQ-023 The index SHALL be WIDTH+1 bits wide so that N=2^WIDTH does not wrap before the final compare.
REQ-024 On the final transfer (count reaches N), the FSM SHALL enter DONE.
REQ-025 In DONE, valid=0, busy=0 and done=1 for exactly one cycle, then the FSM SHALL enter IDLE.
REQ-026 In IDLE, vec SHALL hold the last presented vector, and count SHALL hold its final value until the next start.
REQ-027 abort=1 in PRESENT or GAP: the FSM SHALL enter IDLE on the next cycle with valid=0 and busy=0, no done pulse, and count holding the number of completed transfers.
REQ-028 Abort SHALL take priority over a same-cycle transfer; that transfer still counts because it has completed.
REQ-029 start SHALL be ignored outside IDLE, and start together with abort in IDLE SHALL be treated as start.
REQ-030 A start issued in the DONE cycle SHALL be ignored; start is accepted from the first IDLE cycle.
REQ-031 Changes on mode after start SHALL have no effect until the next accepted start.
REQ-032 When ready is tied high and GAP=0, the block SHALL transfer one vector per cycle, giving a sweep latency of N+1 cycles from start to done.

Reset
REQ-033 While rst is high, and asynchronously on its assertion, the outputs SHALL be vec=0, valid=0, busy=0, done=0 and count=0, with state IDLE and mode latch 00.
REQ-034 Assertion of rst mid-sweep SHALL discard the sweep, and no done pulse SHALL follow.
REQ-035 After rst deasserts, the first start SHALL be accepted on the first clock edge at which it is sampled high.

Verification
REQ-036 WIDTH=3, GAP=0, mode 00, ready=1, pulse start -> vec 0..7 on 8 consecutive valid cycles, then done high for 1 cycle, count=8.
REQ-037 WIDTH=3, mode 01 -> sequence 0,1,3,2,6,7,5,4, with exactly one bit changing between consecutive vectors.
REQ-038 WIDTH=5, mode 10, GAP=2 -> sequence 1,2,4,8,16, two valid-low cycles after each transfer, done after the 5th, count=5.
REQ-039 WIDTH=3, mode 11, ready toggled randomly -> sequence 7..0 with vec stable while valid&&!ready, and no vector lost or duplicated.
REQ-040 Abort after the 3rd transfer -> IDLE next cycle, no done, count=3; a new start then restarts the sweep from index 0.
REQ-041 Reset asserted mid-sweep and start asserted in the DONE cycle -> all outputs 0 immediately on reset; the start in DONE is ignored.
